// File: rtl/seg7_readback_pkg.sv
// Shared definitions for the seven-segment readback monitor: glyph patterns
// (active-low, g..a), FSM state encoding and sizing helpers.
package seg7_readback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DECODE  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Keeps the digit index at least one bit wide for a single-digit build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_readback_if.sv
// Request/result handshake between a readback consumer (master) and the
// seven-segment readback monitor (slave).
interface seg7_readback_if #(
    parameter int NDIGIT = 6
);
    logic                  start;
    logic                  ready;
    logic                  busy;
    logic                  valid;
    logic [4*NDIGIT-1:0]   value;
    logic [NDIGIT-1:0]     digit_err;
    logic                  any_err;

    modport master (
        output start, ready,
        input  busy, valid, value, digit_err, any_err
    );

    modport slave (
        input  start, ready,
        output busy, valid, value, digit_err, any_err
    );
endinterface

// File: rtl/seg7_readback_decode.sv
// Combinational seven-segment glyph decoder: active-low g..a pattern in,
// hex nibble plus legality flag out. Unknown patterns decode to 0.
module seg7_decode
    import seg7_readback_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_readback.sv
// Snapshots all HEX display buses on request, decodes one digit per clock
// through a shared decoder and returns value/error flags over valid/ready.
module seg7_readback
    import seg7_readback_pkg::*;
#(
    parameter int NDIGIT         = 6,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7*NDIGIT-1:0] hex_in,
    seg7_readback_if.slave      bus
);

    localparam int              IDXW     = idx_width(NDIGIT);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIGIT - 1);

    state_e              state_q, state_d;
    logic [7*NDIGIT-1:0] snap_q, snap_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [4*NDIGIT-1:0] value_q, value_d;
    logic [NDIGIT-1:0]   err_q, err_d;

    logic [6:0] cur_seg;
    logic [3:0] cur_nibble;
    logic       cur_legal;

    // Snapshot is stored already normalised to active-low polarity.
    assign cur_seg = snap_q[7*idx_q +: 7];

    seg7_decode u_decode (
        .seg    (cur_seg),
        .nibble (cur_nibble),
        .legal  (cur_legal)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        value_d = value_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                snap_d  = SEG_ACTIVE_LOW ? hex_in : ~hex_in;
                value_d = '0;
                err_d   = '0;
                idx_d   = '0;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                value_d[4*idx_q +: 4] = cur_nibble;
                err_d[idx_q]          = ~cur_legal;
                // Index parks on the last digit rather than wrapping.
                if (idx_q == IDX_LAST) state_d = ST_DONE;
                else                   idx_d   = idx_q + 1'b1;
            end
            ST_DONE: begin
                if (bus.ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            value_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.valid     = (state_q == ST_DONE);
    assign bus.value     = value_q;
    assign bus.digit_err = err_q;
    assign bus.any_err   = |err_q;

endmodule
